// File: rtl/controlador_vitais_pkg.sv
// ============================================================================
// controlador_vitais_pkg : pet state encodings and sequencer state types
// Rev 1.0
// ============================================================================
`default_nettype none

package controlador_vitais_pkg;

    localparam logic [3:0] ESTADO_IDLE       = 4'b0000;
    localparam logic [3:0] ESTADO_DORMINDO   = 4'b0001;
    localparam logic [3:0] ESTADO_COMENDO    = 4'b0010;
    localparam logic [3:0] ESTADO_DANDO_AULA = 4'b0100;
    localparam logic [3:0] ESTADO_MORTO      = 4'b1000;

    typedef enum logic [2:0] {
        SEQ_ESPERA   = 3'd0,
        SEQ_FOME     = 3'd1,
        SEQ_ENERGIA  = 3'd2,
        SEQ_CONHEC   = 3'd3,
        SEQ_VERIFICA = 3'd4
    } seq_t;

    typedef enum logic [2:0] {
        PET_IDLE     = 3'd0,
        PET_DORMINDO = 3'd1,
        PET_COMENDO  = 3'd2,
        PET_AULA     = 3'd3,
        PET_MORTO    = 3'd4
    } pet_t;

    // Anything that is not a legal one-hot code behaves as IDLE.
    function automatic pet_t decodifica_estado(input logic [3:0] e);
        pet_t p;
        case (e)
            ESTADO_DORMINDO:   p = PET_DORMINDO;
            ESTADO_COMENDO:    p = PET_COMENDO;
            ESTADO_DANDO_AULA: p = PET_AULA;
            ESTADO_MORTO:      p = PET_MORTO;
            default:           p = PET_IDLE;
        endcase
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_vitais_divisor_tick.sv
// ============================================================================
// divisor_tick : free-running prescaler, one-cycle registered tick per period
// Rev 1.0
// ============================================================================
`default_nettype none

module divisor_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_ultimo = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          tick_d, tick_q;

    // tick is registered alongside the count so it is high exactly while cnt_q is the last value
    always_comb begin
        cnt_d  = (cnt_q == c_ultimo) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == c_ultimo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/controlador_vitais.sv
// ============================================================================
// controlador_vitais : pet vital levels updated one per cycle on each game tick
// Rev 1.0
// ============================================================================
`default_nettype none

module controlador_vitais
    import controlador_vitais_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter int W             = 4,
    parameter int ESQUECE_TICKS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   estado,
    output logic [W-1:0] fome,
    output logic [W-1:0] energia,
    output logic [W-1:0] conhecimento,
    output logic         morreu,
    output logic         tick
);

    localparam int EW = $clog2(ESQUECE_TICKS + 1);
    localparam logic [W-1:0]  c_max     = '1;
    localparam logic [W-1:0]  c_um      = W'(1);
    localparam logic [W-1:0]  c_dois    = W'(2);
    localparam logic [EW-1:0] c_esquece = EW'(ESQUECE_TICKS);

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] v, input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, v} + {1'b0, d};
        return s[W] ? c_max : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] v, input logic [W-1:0] d);
        return (v < d) ? '0 : v - d;
    endfunction

    logic w_tick;

    divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    seq_t          seq_d, seq_q;
    logic [3:0]    est_d, est_q;
    logic [EW-1:0] esq_d, esq_q;
    logic [W-1:0]  fome_d, fome_q;
    logic [W-1:0]  energia_d, energia_q;
    logic [W-1:0]  conhec_d, conhec_q;
    logic          morreu_d, morreu_q;
    logic [EW-1:0] w_esq_inc;
    pet_t          w_pet;
    logic          w_congelado;

    always_comb begin
        seq_d       = seq_q;
        est_d       = est_q;
        esq_d       = esq_q;
        fome_d      = fome_q;
        energia_d   = energia_q;
        conhec_d    = conhec_q;
        morreu_d    = morreu_q;
        w_pet       = decodifica_estado(est_q);
        w_congelado = morreu_q || (w_pet == PET_MORTO);
        w_esq_inc   = esq_q + EW'(1);

        case (seq_q)
            SEQ_ESPERA: begin
                if (w_tick) begin
                    est_d = estado;
                    seq_d = SEQ_FOME;
                end
            end
            SEQ_FOME: begin
                if (!w_congelado) begin
                    fome_d = (w_pet == PET_COMENDO) ? sat_sub(fome_q, c_dois)
                                                    : sat_add(fome_q, c_um);
                end
                seq_d = SEQ_ENERGIA;
            end
            SEQ_ENERGIA: begin
                if (!w_congelado) begin
                    case (w_pet)
                        PET_DORMINDO: energia_d = sat_add(energia_q, c_dois);
                        PET_AULA:     energia_d = sat_sub(energia_q, c_dois);
                        default:      energia_d = sat_sub(energia_q, c_um);
                    endcase
                end
                seq_d = SEQ_CONHEC;
            end
            SEQ_CONHEC: begin
                if (!w_congelado) begin
                    if (w_pet == PET_AULA) begin
                        conhec_d = sat_add(conhec_q, c_um);
                        esq_d    = '0;
                    end else if (w_esq_inc == c_esquece) begin
                        conhec_d = sat_sub(conhec_q, c_um);
                        esq_d    = '0;
                    end else begin
                        esq_d    = w_esq_inc;
                    end
                end
                seq_d = SEQ_VERIFICA;
            end
            SEQ_VERIFICA: begin
                if ((fome_q == c_max) || (energia_q == '0)) begin
                    morreu_d = 1'b1;
                end
                seq_d = SEQ_ESPERA;
            end
            default: seq_d = SEQ_ESPERA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q     <= SEQ_ESPERA;
            est_q     <= ESTADO_IDLE;
            esq_q     <= '0;
            fome_q    <= '0;
            energia_q <= c_max;
            conhec_q  <= '0;
            morreu_q  <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            est_q     <= est_d;
            esq_q     <= esq_d;
            fome_q    <= fome_d;
            energia_q <= energia_d;
            conhec_q  <= conhec_d;
            morreu_q  <= morreu_d;
        end
    end

    assign fome         = fome_q;
    assign energia      = energia_q;
    assign conhecimento = conhec_q;
    assign morreu       = morreu_q;
    assign tick         = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_controlador_vitais.sv
// ============================================================================
// tb_controlador_vitais : directed self-checking bench for controlador_vitais
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_controlador_vitais;

    localparam logic [3:0] E_IDLE  = 4'b0000;
    localparam logic [3:0] E_DORM  = 4'b0001;
    localparam logic [3:0] E_COME  = 4'b0010;
    localparam logic [3:0] E_AULA  = 4'b0100;

    logic       clk;
    logic       rst_n;
    logic [3:0] estado;
    logic [3:0] fome, energia, conhecimento;
    logic       morreu, tick;

    int checks   = 0;
    int failures = 0;

    controlador_vitais #(
        .TICK_DIV      (8),
        .W             (4),
        .ESQUECE_TICKS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .estado       (estado),
        .fome         (fome),
        .energia      (energia),
        .conhecimento (conhecimento),
        .morreu       (morreu),
        .tick         (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Release happens on a negedge; that cycle counts as cycle 1 after release.
    task automatic do_reset();
        rst_n  = 1'b0;
        estado = E_IDLE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns the number of negedges waited until tick is seen high.
    task automatic wait_tick(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            n = i;
            if (tick) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 0, 1);
    endtask

    task automatic run_ticks(input int k, input logic [3:0] est);
        int n;
        estado = est;
        for (int i = 0; i < k; i++) wait_tick(n);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        estado = E_IDLE;

        // 1. reset state, tick timing, IDLE drift
        do_reset();
        chk("rst_fome", fome, 0);
        chk("rst_energia", energia, 15);
        chk("rst_conhec", conhecimento, 0);
        chk("rst_morreu", morreu, 0);
        chk("rst_tick", tick, 0);
        wait_tick(n); chk("tick1_gap", n, 7);
        wait_tick(n); chk("tick2_gap", n, 8);
        wait_tick(n); chk("tick3_gap", n, 8);
        repeat (5) @(negedge clk);
        chk("t1_fome", fome, 3);
        chk("t1_energia", energia, 12);
        chk("t1_conhec", conhecimento, 0);
        chk("t1_morreu", morreu, 0);

        // 2. saturation at MAX and at 0
        do_reset();
        run_ticks(1, E_IDLE);
        chk("t2_fome_a", fome, 1);
        chk("t2_energia_a", energia, 14);
        run_ticks(1, E_DORM);
        chk("t2_energia_sat", energia, 15);
        run_ticks(1, E_COME);
        chk("t2_fome_zero", fome, 0);
        run_ticks(1, E_COME);
        chk("t2_fome_sat0", fome, 0);
        chk("t2_energia_b", energia, 13);
        chk("t2_conhec_sat0", conhecimento, 0);

        // 3. teaching and forgetting
        do_reset();
        run_ticks(5, E_AULA);
        chk("t3_conhec_aula", conhecimento, 5);
        chk("t3_energia_aula", energia, 5);
        chk("t3_fome_aula", fome, 5);
        run_ticks(3, E_IDLE);
        chk("t3_conhec_3idle", conhecimento, 5);
        run_ticks(1, E_IDLE);
        chk("t3_conhec_4idle", conhecimento, 4);
        chk("t3_energia_4idle", energia, 1);

        // 4. latency and estado latching
        do_reset();
        run_ticks(1, E_IDLE);
        estado = E_COME;
        wait_tick(n);
        chk("t4_fome_T", fome, 1);
        @(negedge clk);
        estado = E_DORM;
        chk("t4_fome_T1", fome, 1);
        @(negedge clk);
        chk("t4_fome_T2", fome, 0);
        chk("t4_energia_T2", energia, 14);
        @(negedge clk);
        chk("t4_energia_T3", energia, 13);
        repeat (3) @(negedge clk);

        // 5. death and freezing
        do_reset();
        estado = E_IDLE;
        for (int i = 0; i < 14; i++) wait_tick(n);
        repeat (5) @(negedge clk);
        chk("t5_morreu_14", morreu, 0);
        wait_tick(n);
        repeat (2) @(negedge clk);
        chk("t5_fome_T2", fome, 15);
        @(negedge clk);
        chk("t5_energia_T3", energia, 0);
        @(negedge clk);
        chk("t5_morreu_T4", morreu, 0);
        @(negedge clk);
        chk("t5_morreu_T5", morreu, 1);
        run_ticks(3, E_COME);
        chk("t5_fome_frozen", fome, 15);
        chk("t5_energia_frozen", energia, 0);
        chk("t5_morreu_sticky", morreu, 1);

        // 6. asynchronous reset in the middle of a sequence
        do_reset();
        estado = E_IDLE;
        wait_tick(n);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_fome", fome, 0);
        chk("t6_async_energia", energia, 15);
        chk("t6_async_conhec", conhecimento, 0);
        chk("t6_async_morreu", morreu, 0);
        chk("t6_async_tick", tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        chk("t6_tick_gap", n, 7);
        chk("t6_fome_norem", fome, 0);
        chk("t6_energia_norem", energia, 15);
        repeat (5) @(negedge clk);
        chk("t6_fome_after", fome, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
